// File: rtl/vred_seq_ctrl_pkg.sv
// Shared definitions for the vector reduction sequencer: FSM state encoding,
// element-width codes, operand-select codes and the opcode values used when
// exercising the reduction unit.
package vred_seq_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_FIRST  = 4'd1,
        ST_ACC    = 4'd2,
        ST_ACC_W  = 4'd3,
        ST_FOLD   = 4'd4,
        ST_FOLD_W = 4'd5,
        ST_SEED   = 4'd6,
        ST_SEED_W = 4'd7,
        ST_DONE   = 4'd8
    } state_e;

    // Which value is placed in the opB half of the unit operand
    typedef enum logic [1:0] {
        OPND_BEAT = 2'd0,
        OPND_FOLD = 2'd1,
        OPND_SEED = 2'd2
    } opnd_e;

    localparam logic [1:0] SEW_8  = 2'd0;
    localparam logic [1:0] SEW_16 = 2'd1;
    localparam logic [1:0] SEW_32 = 2'd2;

    localparam int OPSEL_ADD_BIT = 3;

    // Unit opcodes: bit3 selects add; otherwise bit0 = max, bit1 = signed
    localparam logic [8:0] OPSEL_SUM  = 9'h008;
    localparam logic [8:0] OPSEL_MINU = 9'h000;
    localparam logic [8:0] OPSEL_MAXU = 9'h001;
    localparam logic [8:0] OPSEL_MIN  = 9'h002;
    localparam logic [8:0] OPSEL_MAX  = 9'h003;

    // Number of in-register halving steps needed to bring a full beat down to lane 0
    function automatic logic [1:0] folds_for_sew(input logic [1:0] sew);
        case (sew)
            SEW_8:   return 2'd2;
            SEW_16:  return 2'd1;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/vred_seq_ctrl_opmux.sv
// Combinational operand former for the reduction sequencer: selects the opB
// source (incoming beat, shifted accumulator for folding, zero-extended seed)
// and masks the accumulator down to the active element width for the result.
module vred_seq_opmux
    import vred_seq_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int SEW_WIDTH  = 2
) (
    input  logic                    en,
    input  opnd_e                   sel,
    input  logic [SEW_WIDTH-1:0]    sew,
    input  logic [1:0]              folds_left,
    input  logic [DATA_WIDTH-1:0]   acc,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic [DATA_WIDTH-1:0]   seed,
    output logic [2*DATA_WIDTH-1:0] vec0,
    output logic [DATA_WIDTH-1:0]   acc_masked
);

    function automatic logic [DATA_WIDTH-1:0] sew_mask(input logic [SEW_WIDTH-1:0] s);
        logic [DATA_WIDTH-1:0] m;
        m = '1;
        case (s)
            SEW_WIDTH'(SEW_8):  m = {{(DATA_WIDTH-8){1'b0}}, 8'hFF};
            SEW_WIDTH'(SEW_16): m = {{(DATA_WIDTH-16){1'b0}}, 16'hFFFF};
            default:            m = '1;
        endcase
        return m;
    endfunction

    logic [DATA_WIDTH-1:0] mask;
    logic [DATA_WIDTH-1:0] fold_opnd;
    logic [DATA_WIDTH-1:0] opnd_b;

    assign mask = sew_mask(sew);

    // First fold always halves the beat; only the second byte-wide fold uses a quarter shift
    assign fold_opnd = (sew == SEW_WIDTH'(SEW_8) && folds_left == 2'd1)
                     ? (acc >> (DATA_WIDTH / 4))
                     : (acc >> (DATA_WIDTH / 2));

    // Pick the opB operand for the current issue cycle
    always_comb begin
        opnd_b = '0;
        case (sel)
            OPND_BEAT: opnd_b = in_data;
            OPND_FOLD: opnd_b = fold_opnd;
            OPND_SEED: opnd_b = seed & mask;
            default:   opnd_b = '0;
        endcase
    end

    // Operand bus stays at zero whenever the unit is not being issued to
    assign vec0       = en ? {opnd_b, acc} : '0;
    assign acc_masked = acc & mask;

endmodule

// File: rtl/vred_seq_ctrl.sv
// Vector reduction sequencer: accepts a reduction request, streams packed beats
// through the shared reduction unit into a lane-wise accumulator, folds the
// accumulator to a single element, merges the scalar seed and returns one result.
module vred_seq_ctrl
    import vred_seq_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int RESP_WIDTH  = 64,
    parameter int OPSEL_WIDTH = 9,
    parameter int SEW_WIDTH   = 2,
    parameter int CNT_WIDTH   = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_valid,
    output logic                    start_ready,
    input  logic [SEW_WIDTH-1:0]    start_sew,
    input  logic [OPSEL_WIDTH-1:0]  start_opsel,
    input  logic [DATA_WIDTH-1:0]   start_seed,
    input  logic [CNT_WIDTH-1:0]    start_nbeats,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic                    abort,
    output logic [2*DATA_WIDTH-1:0] red_vec0,
    output logic                    red_en,
    output logic [SEW_WIDTH-1:0]    red_sew,
    output logic [OPSEL_WIDTH-1:0]  red_opsel,
    input  logic [RESP_WIDTH-1:0]   red_out_vec,
    output logic                    out_valid,
    output logic [DATA_WIDTH-1:0]   out_data,
    input  logic                    out_ready,
    output logic                    busy
);

    state_e                  state, nxt_state;
    opnd_e                   opnd_sel;
    logic [CNT_WIDTH-1:0]    beats_left;
    logic [1:0]              folds_left;
    logic [DATA_WIDTH-1:0]   acc;
    logic [DATA_WIDTH-1:0]   seed_q;
    logic [SEW_WIDTH-1:0]    sew_q;
    logic [OPSEL_WIDTH-1:0]  opsel_q;
    logic [DATA_WIDTH-1:0]   acc_masked;
    logic [SEW_WIDTH-1:0]    sew_norm;
    logic [1:0]              folds_init;
    logic                    beat_hs;
    logic                    start_take;
    logic                    unused_resp_hi;

    assign unused_resp_hi = ^red_out_vec[RESP_WIDTH-1:DATA_WIDTH];

    // The illegal width code 3 behaves as 32-bit elements
    assign sew_norm   = (start_sew > SEW_WIDTH'(SEW_32)) ? SEW_WIDTH'(SEW_32) : start_sew;
    assign folds_init = folds_for_sew(2'(sew_norm));
    assign beat_hs    = in_valid && in_ready;
    assign start_take = (state == ST_IDLE) && start_valid && !abort;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= nxt_state;
    end

    // Next-state logic; abort overrides everything and returns to IDLE
    always_comb begin
        nxt_state = state;
        case (state)
            ST_IDLE:   if (start_valid)
                           nxt_state = (start_nbeats == '0) ? ST_DONE : ST_FIRST;
            ST_FIRST:  if (beat_hs)
                           nxt_state = (beats_left > CNT_WIDTH'(1)) ? ST_ACC
                                     : (folds_left != 2'd0) ? ST_FOLD : ST_SEED;
            ST_ACC:    if (beat_hs) nxt_state = ST_ACC_W;
            ST_ACC_W:  nxt_state = (beats_left != '0) ? ST_ACC
                                 : (folds_left != 2'd0) ? ST_FOLD : ST_SEED;
            ST_FOLD:   nxt_state = ST_FOLD_W;
            ST_FOLD_W: nxt_state = (folds_left > 2'd1) ? ST_FOLD : ST_SEED;
            ST_SEED:   nxt_state = ST_SEED_W;
            ST_SEED_W: nxt_state = ST_DONE;
            ST_DONE:   if (out_ready) nxt_state = ST_IDLE;
            default:   nxt_state = ST_IDLE;
        endcase
        if (abort) nxt_state = ST_IDLE;
    end

    // Per-state handshake and unit-issue outputs
    always_comb begin
        start_ready = 1'b0;
        in_ready    = 1'b0;
        red_en      = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b1;
        opnd_sel    = OPND_BEAT;
        case (state)
            ST_IDLE:  begin start_ready = 1'b1; busy = 1'b0; end
            ST_FIRST: in_ready = 1'b1;
            ST_ACC:   begin in_ready = 1'b1; red_en = in_valid; end
            ST_FOLD:  begin red_en = 1'b1; opnd_sel = OPND_FOLD; end
            ST_SEED:  begin red_en = 1'b1; opnd_sel = OPND_SEED; end
            ST_DONE:  out_valid = 1'b1;
            default:  ;
        endcase
    end

    // Request latches, beat/fold counters and the lane-wise accumulator
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beats_left <= '0;
            folds_left <= '0;
            acc        <= '0;
            seed_q     <= '0;
            sew_q      <= '0;
            opsel_q    <= '0;
        end else begin
            case (state)
                ST_IDLE: if (start_take) begin
                    sew_q      <= sew_norm;
                    opsel_q    <= start_opsel;
                    seed_q     <= start_seed;
                    beats_left <= start_nbeats;
                    folds_left <= folds_init;
                    if (start_nbeats == '0) acc <= start_seed;
                end
                ST_FIRST: if (beat_hs) begin
                    acc        <= in_data;
                    beats_left <= beats_left - CNT_WIDTH'(1);
                end
                ST_ACC: if (beat_hs) beats_left <= beats_left - CNT_WIDTH'(1);
                ST_ACC_W:  acc <= red_out_vec[DATA_WIDTH-1:0];
                ST_FOLD_W: begin
                    acc        <= red_out_vec[DATA_WIDTH-1:0];
                    folds_left <= folds_left - 2'd1;
                end
                ST_SEED_W: acc <= red_out_vec[DATA_WIDTH-1:0];
                default:   ;
            endcase
        end
    end

    vred_seq_opmux #(
        .DATA_WIDTH (DATA_WIDTH),
        .SEW_WIDTH  (SEW_WIDTH)
    ) u_opmux (
        .en         (red_en),
        .sel        (opnd_sel),
        .sew        (sew_q),
        .folds_left (folds_left),
        .acc        (acc),
        .in_data    (in_data),
        .seed       (seed_q),
        .vec0       (red_vec0),
        .acc_masked (acc_masked)
    );

    assign red_sew   = sew_q;
    assign red_opsel = opsel_q;
    assign out_data  = out_valid ? acc_masked : '0;

endmodule

// File: tb/tb_vred_seq_ctrl.sv
// Testbench for vred_seq_ctrl: models the reduction unit, drives directed and
// random reductions, and checks results through a scoreboard against a
// whole-vector reference reduction.
module tb_vred_seq_ctrl;
    import vred_seq_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_valid, start_ready;
    logic [1:0]  start_sew;
    logic [8:0]  start_opsel;
    logic [31:0] start_seed;
    logic [5:0]  start_nbeats;
    logic        in_valid, in_ready;
    logic [31:0] in_data;
    logic        abort;
    logic [63:0] red_vec0;
    logic        red_en;
    logic [1:0]  red_sew;
    logic [8:0]  red_opsel;
    logic [63:0] red_out_vec = '0;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic        busy;

    always #5 clk = ~clk;

    vred_seq_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .start_sew    (start_sew),
        .start_opsel  (start_opsel),
        .start_seed   (start_seed),
        .start_nbeats (start_nbeats),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .abort        (abort),
        .red_vec0     (red_vec0),
        .red_en       (red_en),
        .red_sew      (red_sew),
        .red_opsel    (red_opsel),
        .red_out_vec  (red_out_vec),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ready    (out_ready),
        .busy         (busy)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] data;
        int          ens;
        int          lat;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] beat_q[$];

    task automatic check(input string name, input longint act, input longint expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    function automatic int esz_of(input logic [1:0] sew);
        return (sew == SEW_8) ? 8 : (sew == SEW_16) ? 16 : 32;
    endfunction

    function automatic longint sext(input longint x, input int esz);
        return ((x >> (esz - 1)) & 1) ? x - (longint'(1) << esz) : x;
    endfunction

    // One element-wide operation of the reduction unit
    function automatic longint op_elem(input longint a_in, input longint b_in,
                                       input int esz, input logic [8:0] op);
        longint m, a, b, sa, sb;
        m = (longint'(1) << esz) - 1;
        a = a_in & m;
        b = b_in & m;
        if (op[OPSEL_ADD_BIT]) return (a + b) & m;
        sa = op[1] ? sext(a, esz) : a;
        sb = op[1] ? sext(b, esz) : b;
        if (op[0]) return (sa >= sb) ? a : b;
        return (sa <= sb) ? a : b;
    endfunction

    function automatic logic [31:0] unit_lanes(input logic [31:0] opb, input logic [31:0] opa,
                                               input logic [1:0] sew, input logic [8:0] op);
        int     esz;
        longint r;
        esz = esz_of(sew);
        r = 0;
        for (int l = 0; l < 32 / esz; l++)
            r |= op_elem(longint'(opa) >> (l * esz), longint'(opb) >> (l * esz), esz, op) << (l * esz);
        return r[31:0];
    endfunction

    // Reference: fold every element of every beat, plus the seed, with the element operation
    function automatic logic [31:0] ref_reduce(input logic [1:0] sew, input logic [8:0] op,
                                               input logic [31:0] seed);
        int     esz;
        longint acc;
        esz = esz_of(sew);
        acc = longint'(seed) & ((longint'(1) << esz) - 1);
        foreach (beat_q[i])
            for (int l = 0; l < 32 / esz; l++)
                acc = op_elem(acc, longint'(beat_q[i]) >> (l * esz), esz, op);
        return acc[31:0];
    endfunction

    // Reduction unit model: one registered cycle of latency
    always @(posedge clk)
        if (red_en) red_out_vec <= {32'h0, unit_lanes(red_vec0[63:32], red_vec0[31:0], red_sew, red_opsel)};

    // Monitor / scoreboard
    int          cyc = 0, ens_cnt = 0, beat0_cyc = 0, lat_meas = 0;
    bit          first_pending = 0, prev_ov = 0, prev_hold = 0;
    logic [31:0] prev_data = '0;
    exp_t        e;

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            first_pending = 0;
            prev_ov       = 0;
            prev_hold     = 0;
        end else begin
            if (start_valid && start_ready && !abort) begin
                first_pending = 1;
                ens_cnt       = 0;
            end
            if (red_en) ens_cnt++;
            if (first_pending && in_valid && in_ready) begin
                beat0_cyc     = cyc;
                first_pending = 0;
            end
            if (!busy) check("idle_unit_bus", {red_en, red_vec0}, 0);
            if (prev_hold) begin
                check("hold_out_valid", out_valid, 1);
                check("hold_out_data", out_data, prev_data);
            end
            if (out_valid) begin
                check("start_ready_in_done", start_ready, 0);
                if (!prev_ov) lat_meas = cyc - beat0_cyc;
            end
            if (out_valid && out_ready) begin
                check("result_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("out_data", out_data, e.data);
                    check("red_en_count", ens_cnt, e.ens);
                    if (e.lat > 0) check("latency", lat_meas, e.lat);
                end
            end
            prev_hold = out_valid && !out_ready;
            prev_data = out_data;
            prev_ov   = out_valid;
        end
    end

    task automatic start_req(input logic [1:0] sew, input logic [8:0] op,
                             input logic [31:0] seed, input int nbeats);
        int n;
        start_valid  = 1'b1;
        start_sew    = sew;
        start_opsel  = op;
        start_seed   = seed;
        start_nbeats = 6'(nbeats);
        n = 0;
        while (!start_ready && n < 100) begin @(posedge clk); #1; n++; end
        check("start_ready_wait", start_ready, 1);
        @(posedge clk); #1;
        start_valid = 1'b0;
    endtask

    task automatic feed_beat(input logic [31:0] d, input int gap);
        int n;
        in_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        in_valid = 1'b1;
        in_data  = d;
        n = 0;
        while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
        check("in_ready_wait", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Full reduction using the beats in beat_q
    task automatic do_op(input logic [1:0] sew, input logic [8:0] op, input logic [31:0] seed,
                         input int gapmax, input int hold, input int lat);
        exp_t x;
        int   nb, n, folds;
        logic [1:0] sn;
        nb    = beat_q.size();
        sn    = (sew == 2'd3) ? SEW_32 : sew;
        folds = (sn == SEW_8) ? 2 : (sn == SEW_16) ? 1 : 0;
        x.data = ref_reduce(sn, op, seed);
        x.ens  = (nb == 0) ? 0 : (nb - 1) + folds + 1;
        x.lat  = lat;
        exp_q.push_back(x);
        start_req(sew, op, seed, nb);
        foreach (beat_q[i]) feed_beat(beat_q[i], (gapmax > 0) ? $urandom_range(0, gapmax) : 0);
        n = 0;
        while (!out_valid && n < 300) begin @(posedge clk); #1; n++; end
        check("out_valid_wait", out_valid, 1);
        repeat (hold) begin @(posedge clk); #1; end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    logic [8:0] ops[5] = '{OPSEL_SUM, OPSEL_MINU, OPSEL_MAXU, OPSEL_MIN, OPSEL_MAX};

    initial begin
        rst = 1'b0;
        start_valid = 0; start_sew = 0; start_opsel = 0; start_seed = 0; start_nbeats = 0;
        in_valid = 0; in_data = 0; abort = 0; out_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_start_ready", start_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_red_en", red_en, 0);
        check("rst_red_vec0", red_vec0, 0);
        rst = 1'b1;
        @(posedge clk); #1;

        beat_q = '{32'd1, 32'd2, 32'd3, 32'd4};
        do_op(SEW_32, OPSEL_SUM, 32'd10, 0, 0, 9);
        beat_q = '{32'h04030201};
        do_op(SEW_8, OPSEL_SUM, 32'd5, 0, 0, 7);
        beat_q = '{32'h00070003, 32'h00020009};
        do_op(SEW_16, OPSEL_MAXU, 32'd4, 0, 1, 0);
        beat_q.delete();
        do_op(SEW_16, OPSEL_SUM, 32'hDEADBEEF, 0, 0, 0);
        beat_q = '{32'h80FF7F01, 32'h00010203};
        do_op(SEW_8, OPSEL_MIN, 32'h0000007E, 0, 5, 0);

        for (int t = 0; t < 40; t++) begin
            int nb;
            nb = $urandom_range(0, 6);
            beat_q.delete();
            for (int i = 0; i < nb; i++) beat_q.push_back($urandom);
            do_op(2'($urandom_range(0, 3)), ops[$urandom_range(0, 4)], $urandom,
                  2, $urandom_range(0, 2), 0);
        end

        // Abort while waiting on the unit result
        start_req(SEW_32, OPSEL_SUM, 32'd1, 3);
        feed_beat(32'd1, 0);
        feed_beat(32'd2, 0);
        check("accw_busy", busy, 1);
        check("accw_in_ready", in_ready, 0);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_start_ready", start_ready, 1);
        check("abort_out_valid", out_valid, 0);

        // Reset in the middle of accumulating
        start_req(SEW_16, OPSEL_MAXU, 32'd3, 3);
        feed_beat(32'd7, 0);
        check("acc_busy", busy, 1);
        rst = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_start_ready", start_ready, 1);
        check("midrst_in_ready", in_ready, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        check("postrst_busy", busy, 0);
        check("postrst_out_valid", out_valid, 0);

        // Abort and request together in IDLE: request dropped
        start_valid = 1'b1; start_nbeats = 6'd2; abort = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0; abort = 1'b0;
        check("abort_wins_busy", busy, 0);

        beat_q = '{32'h11111111, 32'h22222222, 32'h33333333};
        do_op(SEW_32, OPSEL_MAXU, 32'h00000005, 0, 0, 7);

        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
